// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: default frame
// geometry and the FSM state encoding.
package fifo_uart_tx_pkg;

    localparam int DEFAULT_D_WIDTH      = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while the transmitter is in a
// timed state and flags the last cycle of each serial bit.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clr_i,
    output logic bit_tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: held at zero when idle or on a state change, wraps at the bit end.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = run_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from an upstream FIFO with registered
// read data and sends each as start bit, d_width data bits LSB first, stop bit.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int d_width      = DEFAULT_D_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    input  logic               tx_en,
    input  logic               fifo_empty,
    input  logic [d_width-1:0] fifo_data,
    output logic               rd_en,
    output logic               tx,
    output logic               busy,
    output logic               frame_done
);

    localparam int BIT_W = (d_width > 1) ? $clog2(d_width) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(d_width - 1);

    state_t             state_q, state_d;
    logic [d_width-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               tx_q, tx_d;
    logic               bit_tick;
    logic               baud_run;
    logic               baud_clr;

    // The bit timer only runs on the serial states and restarts whenever the state moves.
    assign baud_run = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign baud_clr = (state_d != state_q);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i     (rd_clk),
        .rst_i     (rd_rst),
        .run_i     (baud_run),
        .clr_i     (baud_clr),
        .bit_tick_o(bit_tick)
    );

    // Next-state, datapath and registered-line value; tx_d follows the state being entered.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d = fifo_data;
                state_d = ST_START;
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset drops any frame in flight and idles the line.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign rd_en      = (state_q == ST_POP);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP) && bit_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, d_width=8.
// A queue stands in for the upstream FIFO; expected line values come from
// the frame rules (start 0, data LSB first, stop 1, fixed bit length).
module tb_fifo_uart_tx;

    localparam int C  = 4;
    localparam int DW = 8;
    localparam int F  = (DW + 2) * C;

    logic       rd_clk = 1'b0;
    logic       rd_rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         pops   = 0;
    int         frames = 0;
    logic [7:0] model_q[$];
    logic [7:0] last_pop = 8'h00;

    fifo_uart_tx #(
        .d_width     (DW),
        .CLKS_PER_BIT(C)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .tx_en     (tx_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 rd_clk = ~rd_clk;

    // Advance one cycle; observe at the falling edge and serve a pop like a registered-read FIFO.
    task automatic step();
        @(negedge rd_clk);
        cyc++;
        if (rd_en === 1'b1) begin
            checks++;
            if (model_q.size() == 0) begin
                errors++;
                $display("FAIL underflow_pop: rd_en=1 while FIFO empty at cycle %0d, want rd_en=0", cyc);
            end else begin
                last_pop  = model_q.pop_front();
                fifo_data = last_pop;
                pops++;
            end
        end
        fifo_empty = (model_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        model_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Expected line level at cycle i of a frame counted from START entry.
    function automatic logic exp_tx(input int i, input logic [7:0] b);
        logic [7:0] t;
        if (i < C) return 1'b0;
        if (i < (DW + 1) * C) begin
            t = b >> ((i - C) / C);
            return t[0];
        end
        return 1'b1;
    endfunction

    // Wait for the pop, then follow one frame cycle by cycle.
    // drop_idx: frame cycle at which tx_en is cleared; rst_idx: frame cycle at which reset hits.
    task automatic run_frame(input int exp_wait, input int drop_idx, input int rst_idx);
        int         n;
        int         idle_bad;
        int         tx_bad;
        int         busy_bad;
        int         rd_bad;
        int         fd_cnt;
        logic       fd_last;
        logic       got;
        logic       first_got;
        logic       first_want;
        logic [7:0] b;
        logic [7:0] dec;
        n = 0; idle_bad = 0; tx_bad = 0; busy_bad = 0; rd_bad = 0; fd_cnt = 0;
        fd_last = 1'b0; got = 1'b0; dec = 8'h00; first_got = 1'b0; first_want = 1'b0;
        while (!got && n < 60) begin
            step();
            n++;
            if (rd_en === 1'b1) got = 1'b1;
            else if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL pop_timeout: no rd_en within %0d cycles, want a pop", n);
            return;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_line: %0d cycles before pop had tx!=1 or busy!=0, want 0", idle_bad);
        end
        if (exp_wait >= 0) begin
            checks++;
            if (n != exp_wait) begin
                errors++;
                $display("FAIL pop_latency: rd_en after %0d cycles, want %0d", n, exp_wait);
            end
        end
        b = last_pop;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: tx=%b busy=%b rd_en=%b, want 1 1 0", tx, busy, rd_en);
        end
        for (int i = 0; i < F; i++) begin
            if (i == drop_idx) tx_en = 1'b0;
            if (i == rst_idx) begin
                rd_rst = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    step();
                    checks++;
                    if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0 || frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_abort: tx=%b busy=%b rd_en=%b frame_done=%b, want 1 0 0 0",
                                 tx, busy, rd_en, frame_done);
                    end
                end
                rd_rst = 1'b0;
                $display("frame %0d byte=%02h aborted by reset at frame cycle %0d", frames, b, i);
                frames++;
                return;
            end
            step();
            if (tx !== exp_tx(i, b)) begin
                if (tx_bad == 0) begin
                    first_got  = tx;
                    first_want = exp_tx(i, b);
                end
                tx_bad++;
            end
            if (i >= C && i < (DW + 1) * C && ((i - C) % C) == C / 2) dec = {tx, dec[7:1]};
            if (busy !== 1'b1) busy_bad++;
            if (rd_en !== 1'b0) rd_bad++;
            if (frame_done === 1'b1) fd_cnt++;
            if (i == F - 1) fd_last = frame_done;
        end
        checks++;
        if (tx_bad != 0) begin
            errors++;
            $display("FAIL frame_tx: byte %02h had %0d wrong cycles, first got %b want %b",
                     b, tx_bad, first_got, first_want);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL frame_busy: %0d cycles with busy!=1, want 0", busy_bad);
        end
        checks++;
        if (rd_bad != 0) begin
            errors++;
            $display("FAIL frame_rd_en: %0d cycles with rd_en!=0 mid-frame, want 0", rd_bad);
        end
        checks++;
        if (fd_cnt != 1 || fd_last !== 1'b1) begin
            errors++;
            $display("FAIL frame_done: %0d pulses, last-cycle=%b, want 1 pulse in last stop cycle",
                     fd_cnt, fd_last);
        end
        checks++;
        if (dec !== b) begin
            errors++;
            $display("FAIL frame_decode: line decoded %02h, want %02h", dec, b);
        end
        $display("frame %0d byte=%02h decoded=%02h pop_wait=%0d", frames, b, dec, n);
        frames++;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        rd_rst = 1'b1;
        tx_en  = 1'b1;
        push(8'h5A);
        repeat (2) @(posedge rd_clk);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL reset_state: tx=%b rd_en=%b busy=%b frame_done=%b, want 1 0 0 0",
                         tx, rd_en, busy, frame_done);
            end
        end
        $display("reset held 5 cycles with FIFO non-empty, %0d bad cycles", bad);
        rd_rst = 1'b0;
        run_frame(1, -1, -1);
    endtask

    task automatic test_single();
        repeat (3) step();
        push(8'hA5);
        run_frame(1, -1, -1);
    endtask

    task automatic test_back_to_back();
        int pops0;
        repeat (3) step();
        pops0 = pops;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        run_frame(1, -1, -1);
        run_frame(2, -1, -1);
        run_frame(2, -1, -1);
        repeat (10) step();
        checks++;
        if (pops - pops0 != 3) begin
            errors++;
            $display("FAIL b2b_pops: %0d rd_en pulses, want 3", pops - pops0);
        end
        $display("back-to-back: %0d pops for 3 queued bytes", pops - pops0);
    endtask

    task automatic test_empty_idle();
        int bad;
        bad = 0;
        tx_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL empty_idle: %0d of 100 cycles had rd_en/tx/busy wrong, want 0", bad);
        end
        $display("empty idle: 100 cycles, %0d bad", bad);
    endtask

    task automatic test_txen_drop();
        int bad;
        bad = 0;
        repeat (3) step();
        push(8'h81);
        push(8'h42);
        run_frame(1, C + 3 * C + 1, -1);
        for (int k = 0; k < 40; k++) begin
            step();
            if (rd_en !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || model_q.size() != 1) begin
            errors++;
            $display("FAIL txen_hold: %0d rd_en cycles, %0d left in FIFO, want 0 and 1",
                     bad, model_q.size());
        end
        $display("tx_en dropped: %0d extra pops, %0d bytes waiting", bad, model_q.size());
        tx_en = 1'b1;
        run_frame(1, -1, -1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1;
        logic [7:0] b2;
        repeat (3) step();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push(b1);
        push(b2);
        run_frame(1, -1, C + 5 * C + 1);
        run_frame(1, -1, -1);
    endtask

    task automatic test_random();
        repeat (3) step();
        for (int k = 0; k < 6; k++) push(8'($urandom_range(0, 255)));
        run_frame(1, -1, -1);
        for (int k = 1; k < 6; k++) run_frame(2, -1, -1);
    endtask

    initial begin
        rd_rst     = 1'b1;
        tx_en      = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_idle();
        test_txen_drop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is rd_clk, and the reset is rd_rst, synchronous and active-high.
REQ-002 Parameter: d_width, default 8, data word width and number of serial data bits per frame.
REQ-003 Parameter: CLKS_PER_BIT, default 16, rd_clk cycles per serial bit; legal range >= 2.
REQ-004 rd_clk  input  1  clock for all state.
REQ-005 rd_rst  input  1  synchronous active-high reset.
REQ-006 tx_en  input  1  permits starting a new frame.
REQ-007 fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 fifo_data  input  d_width  upstream FIFO registered read data, valid in the cycle after rd_en.
REQ-009 rd_en  output  1  single-cycle pop request to the FIFO.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-013 The FSM SHALL have states IDLE, POP, LOAD, START, DATA and STOP.
REQ-014 IDLE -> POP SHALL occur when tx_en=1 and fifo_empty=0 are both sampled; otherwise the FSM stays in IDLE.
REQ-015 rd_en SHALL be 1 exactly during the POP cycle and 0 in all other states; POP -> LOAD is unconditional.
REQ-016 In LOAD, fifo_data SHALL be captured into the shift register at the closing edge; LOAD -> START is unconditional.
REQ-017 tx SHALL be a registered output: 0 throughout START, shift_reg[0] throughout DATA, 1 throughout STOP and IDLE/POP/LOAD.
REQ-018 Bit timing: START, each DATA bit and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a counter running 0..CLKS_PER_BIT-1.
REQ-019 DATA SHALL send d_width bits LSB first, with the shift register shifting right at each bit boundary and a bit counter running 0..d_width-1.
REQ-020 Frame length from START entry to STOP exit SHALL be (d_width+2)*CLKS_PER_BIT cycles.
REQ-021 frame_done SHALL pulse in the last STOP cycle, and the FSM SHALL then return to IDLE.
REQ-022 Inter-frame gap SHALL be exactly 3 cycles of tx=1 (IDLE, POP, LOAD) between the end of STOP and the next START when the FIFO is still non-empty.
REQ-023 Deasserting tx_en mid-frame SHALL NOT abort the frame: the current frame completes and no new POP follows.
REQ-024 fifo_empty SHALL be ignored outside IDLE; a byte already popped is always transmitted.
REQ-025 rd_en SHALL never assert while fifo_empty=1 was sampled in the preceding IDLE cycle, so there is no underflow pop.
REQ-026 Counter widths SHALL be $clog2(CLKS_PER_BIT) and $clog2(d_width), and counters SHALL NOT wrap outside their defined range.

Reset
REQ-027 On rd_rst=1 at a rising edge, the block SHALL set state=IDLE, tx=1, rd_en=0, busy=0, frame_done=0, and clear all counters and the shift register.
REQ-028 Reset mid-frame SHALL abort the frame: tx=1 from the next cycle, and no rd_en is issued during reset.
REQ-029 After reset release, the first POP SHALL occur no earlier than the second cycle.

Structure
REQ-030 The shared package SHALL hold the state encoding constants, the default CLKS_PER_BIT and the default d_width.
REQ-031 The bit-period counter SHALL be one sub-module, baud_gen, emitting a bit_tick at count CLKS_PER_BIT-1 and cleared on any state change.
REQ-032 All other logic SHALL stay in fifo_uart_tx as a single FSM and its datapath.

Verification (CLKS_PER_BIT=4, d_width=8)
REQ-033 Reset with fifo_empty=0 and tx_en=1 -> tx=1, rd_en=0 and busy=0 during reset; the first rd_en pulse follows reset release.
REQ-034 Single byte 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), with one frame_done pulse.
REQ-035 Three bytes 0x00, 0xFF, 0x3C queued -> three frames in order, with exactly 3 idle-high cycles between frames and exactly 3 rd_en pulses.
REQ-036 fifo_empty=1 for 100 cycles with tx_en=1 -> rd_en stays 0, tx=1 and busy=0 throughout.
REQ-037 tx_en dropped during DATA bit 3 of byte 0x81 -> the frame completes correctly, and no further rd_en occurs although fifo_empty=0.
REQ-038 rd_rst asserted during DATA bit 5 -> tx=1 next cycle, then the FSM resumes from IDLE and the next popped byte is sent intact.
